ps2_keyboard_rx: RTL
====================

Name: ps2_keyboard_rx

Overview:
Parametrised PS/2 keyboard receiver. It replaces the fixed 8-entry receiver with these additions:
- ps2_clk glitch filter.
- Partial-frame timeout.
- Frame-error reporting.
- Optional scan-code-set-2 prefix decoding, which merges E0/F0 prefixes into one key event.
- Configurable-depth FIFO with a fill level output.

It sits between the board PS/2 pins and the CPU I/O bus, which reads it with an active-low rdn strobe.

Parameters:
- AW, 3, log2 of FIFO depth; depth = 2**AW, all entries usable.
- FILTER_LEN, 4, consecutive equal clk samples required before the filtered ps2_clk changes (range 2..15).
- TIMEOUT_CYCLES, 100000, idle clk cycles mid-frame before the frame is aborted (2 ms at 50 MHz).
- DECODE, 1, 1 = merge E0/F0 prefixes into events; 0 = raw byte mode.

Ports:
- clk, input, 1, system clock (50 MHz).
- clrn, input, 1, asynchronous active-low reset.
- ps2_clk, input, 1, PS/2 clock pin (asynchronous).
- ps2_data, input, 1, PS/2 data pin (asynchronous).
- rdn, input, 1, read/pop strobe, active low, sampled at posedge clk.
- data, output, 10, FIFO head {ext, brk, code[7:0]}; 0 when ready=0.
- ready, output, 1, FIFO not empty.
- overflow, output, 1, sticky: an event was dropped because the FIFO was full.
- frame_err, output, 1, one-cycle pulse: frame rejected or aborted.
- level, output, AW+1, number of FIFO entries, 0..2**AW.

Behaviour:
- Reset (clrn=0, async): bit counter, decoder state, pointers and level go to 0. data=0, ready=0, overflow=0, frame_err=0. The filtered clock and both synchronizer stages go to 1. FIFO storage is not reset.
- Input path: ps2_clk and ps2_data each pass through a 2-flop synchronizer.
  - The filtered clock changes only after FILTER_LEN consecutive identical synchronized samples.
  - A sample strobe is one clk cycle on a 1->0 transition of the filtered clock; ps2_data (synchronized) is captured on that cycle.
- Frame format: 11 bits, in order: start (0), d0..d7 (LSB first), odd parity, stop (1). The bit counter runs 0..10.
- On the 11th sample the frame is checked.
  - Valid (start=0, ^{d,parity}=1, stop=1): the byte goes to the decoder.
  - Otherwise: byte discarded, frame_err pulses, decoder returns to IDLE.
  - Either way the counter returns to 0.
- Timeout: the idle counter resets on every sample strobe. If the bit counter ≠ 0 and TIMEOUT_CYCLES clk cycles pass without a strobe, the counter returns to 0, frame_err pulses and the decoder returns to IDLE. No timeout is raised while the bit counter is 0.
- Decoder (DECODE=1), states IDLE, E0, F0, E0F0:
  - Byte E0: IDLE->E0; F0->E0F0 (E0 after F0 is tolerated).
  - Byte F0: IDLE->F0; E0->E0F0.
  - Any other byte: push {ext,brk,byte} and return to IDLE. ext=1 in E0/E0F0; brk=1 in F0/E0F0.
  - A repeated prefix keeps the current state.
  - E1 (Pause) passes through as an ordinary code.
- DECODE=0: every valid byte is pushed as {2'b00, byte}; the decoder FSM is unused.
- Latency: the push occurs at the clk edge ending the cycle in which the stop-bit strobe is seen. ready=1 and data valid from the next cycle.
- FIFO: first-word fall-through; data = head entry combinationally.
  - Pop: rdn=0 && ready at a clk edge advances the read pointer. rdn=0 while empty is ignored.
  - Pointers are AW bits wide and wrap modulo 2**AW; level tracks occupancy explicitly.
- Full (level=2**AW):
  - Push without a pop: event dropped, overflow←1, level unchanged, head unchanged.
  - Push with a simultaneous pop: both performed, level unchanged, no overflow.
- Empty with a simultaneous push and pop: the pop is ignored and the push is accepted (level=1).
- overflow clears on any accepted pop. If a drop and a pop occur in the same cycle, set wins.
- Reset mid-frame: the partial frame is lost. The next complete frame after release is received normally.

Test Plan:
Bench uses a PS/2 model with 40 clk per half ps2 period; TIMEOUT_CYCLES=2000.
- Reset, send frame 0x1C -> ready=1, data=0x01C, level=1; pulse rdn low one cycle -> ready=0, data=0x000, level=0.
- DECODE=1: send E0, F0, 75 -> one push only, data=0x375, level=1. Then send F0, 1C -> data after pop = 0x11C.
- Send 0x1C with wrong parity -> one-cycle frame_err, level stays 0. Send F0, bad-parity 1C, then 2A -> pushed event 0x02A (brk cleared by error).
- AW=3: send 8 bytes 0x10..0x17 -> level=8. Send 9th byte 0x18 -> overflow=1, level=8, data=0x010. Pop once -> overflow=0, level=7. Send 9th byte again with rdn low on the push cycle -> accepted, level unchanged.
- Inject a 2-clk low glitch on ps2_clk -> no sample taken. Send 4 bits, then idle 2500 cycles -> frame_err pulse at 2000 cycles. Then send 0x2A -> data=0x02A.
- Assert clrn asynchronously after bit 5 of a frame with 3 entries queued -> outputs 0 immediately. Release, send 0x1C -> level=1, data=0x01C.

Source files
------------

// File: rtl/ps2_keyboard_rx_if.sv
// CPU-side bus of the PS/2 keyboard receiver: pop strobe plus FIFO head and status.
interface ps2_keyboard_rx_if #(
    parameter int AW = 3
);
    logic          rdn;
    logic [9:0]    data;
    logic          ready;
    logic          overflow;
    logic          frame_err;
    logic [AW:0]   level;

    modport master (output rdn, input data, ready, overflow, frame_err, level);
    modport slave  (input rdn, output data, ready, overflow, frame_err, level);
endinterface

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: synchronised and filtered pins, 11-bit frame check with
// timeout, optional set-2 E0/F0 prefix merging, fall-through event FIFO.
//
// state  | meaning
// S_IDLE | no prefix pending
// S_E0   | extended prefix seen
// S_F0   | break prefix seen
// S_E0F0 | both prefixes seen
module ps2_keyboard_rx #(
    parameter int AW             = 3,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int DECODE         = 1
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic              ps2_clk,
    input  logic              ps2_data,
    ps2_keyboard_rx_if.slave  bus
);
    localparam int          TW         = $clog2(TIMEOUT_CYCLES + 1);
    localparam int          DEPTH      = 2 ** AW;
    localparam logic [AW:0] LEVEL_FULL = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_E0, S_F0, S_E0F0} dec_t;

    logic          clk_s1, clk_s2, dat_s1, dat_s2;
    logic          filt_clk, filt_prev;
    logic [3:0]    filt_cnt;
    logic [3:0]    bit_cnt;
    logic [9:0]    shift;
    logic [TW-1:0] idle_cnt;
    dec_t          state;
    logic          frame_err;
    logic          strobe, frame_ok, byte_valid;
    logic [7:0]    rx_byte;
    logic          push;
    logic [9:0]    push_word;

    logic [9:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   level;
    logic          overflow;
    logic          pop, full, accept, drop;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            clk_s1    <= 1'b1;
            clk_s2    <= 1'b1;
            dat_s1    <= 1'b1;
            dat_s2    <= 1'b1;
            filt_clk  <= 1'b1;
            filt_prev <= 1'b1;
            filt_cnt  <= '0;
        end else begin
            clk_s1    <= ps2_clk;
            clk_s2    <= clk_s1;
            dat_s1    <= ps2_data;
            dat_s2    <= dat_s1;
            filt_prev <= filt_clk;
            if (clk_s2 != filt_clk) begin
                if (filt_cnt == 4'(FILTER_LEN - 1)) begin
                    filt_clk <= clk_s2;
                    filt_cnt <= '0;
                end else begin
                    filt_cnt <= filt_cnt + 4'd1;
                end
            end else begin
                filt_cnt <= '0;
            end
        end
    end

    // After ten strobes shift holds {parity, d7..d0, start}; dat_s2 is the stop bit.
    assign strobe     = filt_prev & ~filt_clk;
    assign rx_byte    = shift[8:1];
    assign frame_ok   = ~shift[0] & (^shift[9:1]) & dat_s2;
    assign byte_valid = strobe && (bit_cnt == 4'd10) && frame_ok;

    always_comb begin
        push      = 1'b0;
        push_word = '0;
        if (byte_valid) begin
            if (DECODE == 0) begin
                push      = 1'b1;
                push_word = {2'b00, rx_byte};
            end else if (rx_byte != 8'hE0 && rx_byte != 8'hF0) begin
                push      = 1'b1;
                push_word = {(state == S_E0) || (state == S_E0F0),
                             (state == S_F0) || (state == S_E0F0), rx_byte};
            end
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            bit_cnt   <= '0;
            shift     <= '0;
            idle_cnt  <= TW'(TIMEOUT_CYCLES - 1);
            state     <= S_IDLE;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (strobe) begin
                idle_cnt <= TW'(TIMEOUT_CYCLES - 1);
                if (bit_cnt == 4'd10) begin
                    bit_cnt <= '0;
                    if (!frame_ok) begin
                        frame_err <= 1'b1;
                        state     <= S_IDLE;
                    end else if (DECODE != 0) begin
                        if (rx_byte == 8'hE0)
                            state <= (state == S_F0 || state == S_E0F0) ? S_E0F0 : S_E0;
                        else if (rx_byte == 8'hF0)
                            state <= (state == S_E0 || state == S_E0F0) ? S_E0F0 : S_F0;
                        else
                            state <= S_IDLE;
                    end
                end else begin
                    shift   <= {dat_s2, shift[9:1]};
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end else if (bit_cnt != 4'd0) begin
                if (idle_cnt == '0) begin
                    bit_cnt   <= '0;
                    frame_err <= 1'b1;
                    state     <= S_IDLE;
                end else begin
                    idle_cnt <= idle_cnt - 1'b1;
                end
            end
        end
    end

    // A pop frees a slot in the same cycle, so a push into a full FIFO alongside a pop is kept.
    assign pop    = ~bus.rdn & (level != '0);
    assign full   = (level == LEVEL_FULL);
    assign accept = push & (~full | pop);
    assign drop   = push & full & ~pop;

    always_ff @(posedge clk) begin
        if (accept)
            mem[wr_ptr] <= push_word;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (accept)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({accept, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (drop)
                overflow <= 1'b1;
            else if (pop)
                overflow <= 1'b0;
        end
    end

    assign bus.ready     = (level != '0);
    assign bus.data      = bus.ready ? mem[rd_ptr] : '0;
    assign bus.level     = level;
    assign bus.overflow  = overflow;
    assign bus.frame_err = frame_err;
endmodule
